sobel_stream_ctrl: RTL and testbench

//  Frame sequencer for the 3x3 Sobel edge kernel. Accepts a raster-order 8-bit pixel stream and

---
 rtl/sobel_stream_ctrl.sv | 155 +++++++++++++++
 tb/tb_sobel_stream_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_stream_ctrl.sv
// Sobel frame sequencer: two line buffers feed a 3x3 window into the
// edge kernel; interior magnitudes leave on a one-deep valid/ready register.
module sobel_kernel (
    input  logic [7:0] p0,
    input  logic [7:0] p1,
    input  logic [7:0] p2,
    input  logic [7:0] p3,
    input  logic [7:0] p5,
    input  logic [7:0] p6,
    input  logic [7:0] p7,
    input  logic [7:0] p8,
    output logic [7:0] mag
);
    logic signed [10:0] gx;
    logic signed [10:0] gy;
    logic [10:0] ax;
    logic [10:0] ay;
    logic [10:0] sum;

    function automatic logic signed [10:0] sx(input logic [7:0] v);
        return $signed({3'b000, v});
    endfunction

    always_comb begin
        gx = (sx(p2) - sx(p0)) + ((sx(p5) - sx(p3)) <<< 1)
           + (sx(p8) - sx(p6));
        gy = (sx(p0) - sx(p6)) + ((sx(p1) - sx(p7)) <<< 1)
           + (sx(p2) - sx(p8));
        ax = gx[10] ? $unsigned(-gx) : $unsigned(gx);
        ay = gy[10] ? $unsigned(-gy) : $unsigned(gy);
        sum = ax + ay;
        mag = (sum > 11'd255) ? 8'hff : sum[7:0];
    end
endmodule

module sobel_stream_ctrl #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       busy,
    output logic       done,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [7:0] s_pixel,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [7:0] m_pixel
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t state;
    state_t state_nx;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [7:0] lb1 [IMG_WIDTH];
    logic [7:0] lb2 [IMG_WIDTH];
    logic [7:0] w0, w1, w3, w4, w6, w7;
    logic [7:0] t2, t5, kout;
    logic accept, col_last, row_last, emit;

    assign s_ready  = (state == RUN) && (!m_valid || m_ready);
    assign busy     = (state == RUN) || (state == DRAIN);
    assign done     = (state == DONE);
    assign accept   = s_valid && s_ready;
    assign col_last = (col == CW'(IMG_WIDTH - 1));
    assign row_last = (row == RW'(IMG_HEIGHT - 1));
    assign emit     = accept && (row >= RW'(2)) && (col >= CW'(2));
    assign t2       = lb2[col];
    assign t5       = lb1[col];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (start) state_nx = RUN;
            RUN:   if (accept && col_last && row_last) state_nx = DRAIN;
            DRAIN: if (!m_valid || m_ready) state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (state == IDLE && start) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col_last) begin
                col <= '0;
                if (!row_last) row <= row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Line buffers need no reset: rows 0/1 fill them before any tap is used.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb2[col] <= lb1[col];
            lb1[col] <= s_pixel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {w0, w1, w3, w4, w6, w7} <= '0;
        end else if (accept) begin
            w0 <= w1;
            w1 <= t2;
            w3 <= w4;
            w4 <= t5;
            w6 <= w7;
            w7 <= s_pixel;
        end
    end

    sobel_kernel u_kernel (
        .p0  (w0),
        .p1  (w1),
        .p2  (t2),
        .p3  (w3),
        .p5  (t5),
        .p6  (w6),
        .p7  (w7),
        .p8  (s_pixel),
        .mag (kout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_pixel <= '0;
        end else if (emit) begin
            m_valid <= 1'b1;
            m_pixel <= kout;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sobel_stream_ctrl.sv
// Scoreboard bench for sobel_stream_ctrl: three instances (4x3, 4x4,
// 8x6) share stimulus; sel picks which one is started and observed.
module tb_sobel_stream_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic s_valid = 1'b0;
    logic m_ready = 1'b0;
    logic [7:0] s_pixel = 8'd0;

    logic busy_v [3];
    logic done_v [3];
    logic s_ready_v [3];
    logic m_valid_v [3];
    logic [7:0] m_pixel_v [3];

    int sel = 0;
    int W = 4;
    int H = 3;
    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int img [$];
    int exp_q [$];

    logic busy, done, s_ready, m_valid;
    logic [7:0] m_pixel;

    always #5 clk = ~clk;

    sobel_stream_ctrl #(.IMG_WIDTH(4), .IMG_HEIGHT(3)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start && sel == 0),
        .busy(busy_v[0]), .done(done_v[0]),
        .s_valid(s_valid), .s_ready(s_ready_v[0]), .s_pixel(s_pixel),
        .m_valid(m_valid_v[0]), .m_ready(m_ready), .m_pixel(m_pixel_v[0]));

    sobel_stream_ctrl #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start && sel == 1),
        .busy(busy_v[1]), .done(done_v[1]),
        .s_valid(s_valid), .s_ready(s_ready_v[1]), .s_pixel(s_pixel),
        .m_valid(m_valid_v[1]), .m_ready(m_ready), .m_pixel(m_pixel_v[1]));

    sobel_stream_ctrl #(.IMG_WIDTH(8), .IMG_HEIGHT(6)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start && sel == 2),
        .busy(busy_v[2]), .done(done_v[2]),
        .s_valid(s_valid), .s_ready(s_ready_v[2]), .s_pixel(s_pixel),
        .m_valid(m_valid_v[2]), .m_ready(m_ready), .m_pixel(m_pixel_v[2]));

    always_comb begin
        busy    = busy_v[sel];
        done    = done_v[sel];
        s_ready = s_ready_v[sel];
        m_valid = m_valid_v[sel];
        m_pixel = m_pixel_v[sel];
    end

    always @(negedge clk) if (done) done_cnt++;

    function automatic int px(input int r, input int c);
        return img[r * W + c];
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic void push_model();
        int gx, gy, s;
        for (int r = 1; r < H - 1; r++) begin
            for (int c = 1; c < W - 1; c++) begin
                gx = (px(r-1,c+1) - px(r-1,c-1)) + 2 * (px(r,c+1) - px(r,c-1))
                   + (px(r+1,c+1) - px(r+1,c-1));
                gy = (px(r-1,c-1) - px(r+1,c-1)) + 2 * (px(r-1,c) - px(r+1,c))
                   + (px(r-1,c+1) - px(r+1,c+1));
                s = iabs(gx) + iabs(gy);
                exp_q.push_back(s > 255 ? 255 : s);
            end
        end
    endfunction

    function automatic void fill_rows(input int a, input int b, input int c, input int d);
        img.delete();
        for (int r = 0; r < H; r++) begin
            img.push_back(a); img.push_back(b);
            img.push_back(c); img.push_back(d);
        end
    endfunction

    function automatic void fill_random();
        img.delete();
        for (int i = 0; i < W * H; i++) img.push_back(int'($urandom_range(255)));
    endfunction

    task automatic run_frame(input string name, input int in_gap,
                             input int out_gap, input bit hold, input bit mid_start);
        int idx = 0;
        int got = 0;
        int n = W * H;
        int nexp = exp_q.size();
        int budget = 40 * W * H + 100;
        done_cnt = 0;
        m_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        fork
            begin
                int cyc = 0;
                while (idx < n && cyc < budget) begin
                    @(negedge clk); #1; cyc++;
                    s_valid = ($urandom_range(99) >= in_gap);
                    s_pixel = 8'(img[idx]);
                    start = mid_start && (idx == n / 2) && (cyc % 2 == 0);
                    if (s_valid && s_ready) idx++;
                end
                @(negedge clk); s_valid = 1'b0; start = 1'b0;
            end
            begin
                int cyc = 0;
                bit held = 1'b0;
                logic [7:0] pix;
                while (got < nexp && cyc < budget) begin
                    @(negedge clk); cyc++;
                    if (hold && !held) begin
                        m_ready = 1'b0; #1;
                        if (m_valid) begin
                            checks++;
                            if (s_ready !== 1'b0) begin
                                errors++;
                                $display("FAIL %s stall_sready: got %0b expected 0", name, s_ready);
                            end
                            pix = m_pixel;
                            repeat (3) @(negedge clk);
                            #1; checks++;
                            if (m_pixel !== pix || m_valid !== 1'b1) begin
                                errors++;
                                $display("FAIL %s stall_hold: got %0d/%0b expected %0d/1",
                                         name, m_pixel, m_valid, pix);
                            end
                            held = 1'b1;
                        end
                    end else begin
                        m_ready = ($urandom_range(99) >= out_gap); #1;
                        if (m_valid && m_ready) begin
                            checks++;
                            if (m_pixel !== 8'(exp_q[0])) begin
                                errors++;
                                $display("FAIL %s out%0d: got %0d expected %0d",
                                         name, got, m_pixel, exp_q[0]);
                            end
                            void'(exp_q.pop_front());
                            got++;
                        end
                    end
                end
            end
        join
        m_ready = 1'b1;
        checks++;
        if (got != nexp) begin
            errors++;
            $display("FAIL %s count: got %0d expected %0d", name, got, nexp);
        end
        exp_q.delete();
        repeat (6) @(negedge clk);
        #1; checks++;
        if (done_cnt != 1 || busy !== 1'b0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s end: done=%0d busy=%0b mvalid=%0b expected 1/0/0",
                     name, done_cnt, busy, m_valid);
        end
    endtask

    task automatic test_reset();
        sel = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            sel = k; #1; checks++;
            if ({busy, done, s_ready, m_valid} !== 4'b0 || m_pixel !== 8'd0) begin
                errors++;
                $display("FAIL reset%0d: got b%0b d%0b s%0b v%0b p%0d expected zeros",
                         k, busy, done, s_ready, m_valid, m_pixel);
            end
        end
        sel = 0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_flat();
        sel = 0; W = 4; H = 3;
        fill_rows(77, 77, 77, 77);
        exp_q.push_back(0); exp_q.push_back(0);
        run_frame("flat", 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_gradient();
        sel = 0; W = 4; H = 3;
        fill_rows(10, 10, 20, 20);
        exp_q.push_back(40); exp_q.push_back(40);
        run_frame("grad_x", 0, 0, 1'b0, 1'b0);
        fill_rows(0, 0, 100, 100);
        exp_q.push_back(255); exp_q.push_back(255);
        run_frame("grad_sat", 0, 0, 1'b0, 1'b0);
        img.delete();
        for (int i = 0; i < 8; i++) img.push_back(0);
        for (int i = 0; i < 4; i++) img.push_back(50);
        exp_q.push_back(200); exp_q.push_back(200);
        run_frame("grad_y", 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_ref4x4();
        sel = 1; W = 4; H = 4;
        fill_random();
        push_model();
        run_frame("ref4x4", 0, 0, 1'b0, 1'b0);
        sel = 0; W = 4; H = 3;
    endtask

    task automatic test_back_to_back();
        sel = 0; W = 4; H = 3;
        fill_random();
        push_model();
        run_frame("backpressure", 0, 0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        sel = 2; W = 8; H = 6;
        fill_random();
        push_model();
        run_frame("random", 30, 30, 1'b0, 1'b1);
        sel = 0; W = 4; H = 3;
    endtask

    task automatic test_midreset();
        sel = 0; W = 4; H = 3;
        m_ready = 1'b1;
        done_cnt = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            s_valid = 1'b1; s_pixel = 8'(i * 30);
        end
        @(negedge clk); s_valid = 1'b0; rst_n = 1'b0;
        #1; checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL midreset: got v%0b b%0b s%0b expected 0/0/0",
                     m_valid, busy, s_ready);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1; checks++;
        if (done_cnt != 0) begin
            errors++;
            $display("FAIL midreset_done: got %0d expected 0", done_cnt);
        end
        fill_random();
        push_model();
        run_frame("after_reset", 10, 10, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_flat();
        test_gradient();
        test_ref4x4();
        test_back_to_back();
        test_random();
        test_midreset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
